// File: rtl/decryption_pkg.sv
// Shared constants and state type for the decryption engines and the demux/mux.
package decryption_pkg;

    localparam int D_WIDTH       = 8;
    localparam int KEY_WIDTH     = 16;
    localparam int MAX_NOF_CHARS = 50;
    localparam logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

    // Buffer address and fill-count widths (count must reach MAX_NOF_CHARS itself).
    localparam int ADDR_W = $clog2(MAX_NOF_CHARS);
    localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
    localparam int HALF_W = KEY_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        DECRYPT,
        FLUSH
    } scytale_state_t;

endpackage

// File: rtl/scytale_decryption_if.sv
// Character stream bundle between the demux path and the scytale engine.
interface scytale_decryption_if;
    import decryption_pkg::*;

    logic [D_WIDTH-1:0]   data_i;
    logic                 valid_i;
    logic [KEY_WIDTH-1:0] key;
    logic                 busy;
    logic [D_WIDTH-1:0]   data_o;
    logic                 valid_o;

    modport slave (
        input  data_i, valid_i, key,
        output busy, data_o, valid_o
    );

    modport master (
        output data_i, valid_i, key,
        input  busy, data_o, valid_o
    );
endinterface

// File: rtl/scytale_decryption_char_buffer.sv
// Message store: one synchronous write port, one registered read port, no reset on storage.
module char_buffer
    import decryption_pkg::*;
(
    input  logic               clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [D_WIDTH-1:0] i_wdata,
    input  logic               i_re,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [D_WIDTH-1:0] o_rdata
);

    logic [D_WIDTH-1:0] r_mem [MAX_NOF_CHARS];
    logic [D_WIDTH-1:0] r_rdata;

    // Write the incoming character; it is readable on the following cycle.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read: one cycle from address to data.
    always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/scytale_decryption.sv
// Scytale decryption engine: buffers a message, then emits it column-wise on the token.
module scytale_decryption
    import decryption_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    scytale_decryption_if.slave  bus
);

    scytale_state_t      r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [HALF_W-1:0]   r_n;
    logic [HALF_W-1:0]   r_m;
    logic [HALF_W-1:0]   r_i;
    logic [HALF_W-1:0]   r_j;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_busy;
    logic                r_valid_o;

    logic                w_is_token;
    logic                w_we;
    logic                w_rd_en;
    logic                w_last_row;
    logic                w_last_col;
    logic                w_bad_key;
    logic [HALF_W-1:0]   w_key_n;
    logic [HALF_W-1:0]   w_key_m;
    logic [KEY_WIDTH-1:0] w_nm;
    logic [D_WIDTH-1:0]  w_rd_data;

    assign w_key_n    = bus.key[KEY_WIDTH-1:HALF_W];
    assign w_key_m    = bus.key[HALF_W-1:0];
    assign w_nm       = KEY_WIDTH'(w_key_n) * KEY_WIDTH'(w_key_m);
    assign w_bad_key  = (w_key_n == '0) || (w_key_m == '0) || (w_nm != KEY_WIDTH'(r_cnt));
    assign w_is_token = (bus.data_i == START_DECRYPTION_TOKEN);
    // Characters beyond the buffer depth are silently dropped.
    assign w_we       = (r_state == IDLE) && !r_busy && bus.valid_i && !w_is_token
                        && (r_cnt < CNT_W'(MAX_NOF_CHARS));
    assign w_rd_en    = (r_state == DECRYPT);
    assign w_last_row = (r_j == r_m - 1'b1);
    assign w_last_col = (r_i == r_n - 1'b1);

    char_buffer u_char_buffer (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_cnt[ADDR_W-1:0]),
        .i_wdata (bus.data_i),
        .i_re    (w_rd_en),
        .i_raddr (r_addr),
        .o_rdata (w_rd_data)
    );

    // FSM: collect characters, walk the buffer column by column, or discard a bad message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_n       <= '0;
            r_m       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_valid_o <= 1'b0;
        end else begin
            // Read data appears one cycle after the address is issued.
            r_valid_o <= w_rd_en;
            case (r_state)
                IDLE: begin
                    if (r_busy) begin
                        // Trailing cycle while the last character drains out.
                        r_busy <= 1'b0;
                    end else if (bus.valid_i) begin
                        if (!w_is_token) begin
                            if (w_we) r_cnt <= r_cnt + CNT_W'(1);
                        end else if (r_cnt != '0) begin
                            r_n    <= w_key_n;
                            r_m    <= w_key_m;
                            r_i    <= '0;
                            r_j    <= '0;
                            r_addr <= '0;
                            r_busy <= 1'b1;
                            r_state <= w_bad_key ? FLUSH : DECRYPT;
                        end
                    end
                end
                DECRYPT: begin
                    // Address is a running sum: +N down a column, restart at the next column.
                    if (w_last_row) begin
                        r_j <= '0;
                        if (w_last_col) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_i     <= '0;
                            r_addr  <= '0;
                        end else begin
                            r_i    <= r_i + 1'b1;
                            r_addr <= ADDR_W'(r_i + 1'b1);
                        end
                    end else begin
                        r_j    <= r_j + 1'b1;
                        r_addr <= r_addr + ADDR_W'(r_n);
                    end
                end
                FLUSH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.valid_o = r_valid_o;
    assign bus.data_o  = r_valid_o ? w_rd_data : '0;

endmodule

// File: tb/tb_scytale_decryption.sv
// Directed testbench for scytale_decryption with hand-computed plaintexts.
module tb_scytale_decryption;
    import decryption_pkg::*;

    typedef logic [7:0] bq_t[$];

    localparam int M_DEC   = 0;
    localparam int M_FLUSH = 1;
    localparam int M_EMPTY = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    scytale_decryption_if bus_if ();

    scytale_decryption dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Sends a message and token (entered at a negedge), then checks the response
    // cycle by cycle; returns at the negedge of the cycle busy has dropped.
    task automatic run_msg(input string name, input bq_t msg, input logic [15:0] k,
                           input int mode, input bq_t exp, input bit junk);
        int n_out;
        n_out = 0;
        for (int i = 0; i < msg.size(); i++) begin
            bus_if.valid_i = 1'b1;
            bus_if.data_i  = msg[i];
            @(negedge clk);
        end
        bus_if.valid_i = 1'b1;
        bus_if.data_i  = START_DECRYPTION_TOKEN;
        bus_if.key     = k;
        @(negedge clk);
        // Cycle t+1; key scrambled to show it was latched on the token cycle.
        bus_if.valid_i = 1'b0;
        bus_if.data_i  = 8'h00;
        bus_if.key     = 16'hFFFF;
        if (mode == M_EMPTY) begin
            check({name, " busy t+1"}, bus_if.busy, 0);
            check({name, " valid t+1"}, bus_if.valid_o, 0);
        end else if (mode == M_FLUSH) begin
            check({name, " busy t+1"}, bus_if.busy, 1);
            check({name, " valid t+1"}, bus_if.valid_o, 0);
            @(negedge clk);
            check({name, " busy t+2"}, bus_if.busy, 0);
            check({name, " valid t+2"}, bus_if.valid_o, 0);
        end else begin
            check({name, " busy t+1"}, bus_if.busy, 1);
            check({name, " valid t+1"}, bus_if.valid_o, 0);
            for (int c = 0; c < exp.size(); c++) begin
                if (junk) begin
                    bus_if.valid_i = 1'b1;
                    bus_if.data_i  = (c == 1) ? START_DECRYPTION_TOKEN : 8'h5A;
                end
                @(negedge clk);
                check($sformatf("%s busy[%0d]", name, c), bus_if.busy, 1);
                check($sformatf("%s valid[%0d]", name, c), bus_if.valid_o, 1);
                check($sformatf("%s data[%0d]", name, c), bus_if.data_o, exp[c]);
                if (bus_if.valid_o) n_out++;
            end
            @(negedge clk);
            bus_if.valid_i = 1'b0;
            bus_if.data_i  = 8'h00;
            check({name, " busy end"}, bus_if.busy, 0);
            check({name, " valid end"}, bus_if.valid_o, 0);
            check({name, " data end"}, bus_if.data_o, 0);
            check({name, " count"}, n_out, exp.size());
        end
        $display("msg %s key=%h len=%0d mode=%0d done", name, k, msg.size(), mode);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t long_msg;
        bq_t long_exp;
        int  seen;

        rst_n          = 1'b0;
        bus_if.valid_i = 1'b0;
        bus_if.data_i  = 8'h00;
        bus_if.key     = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset busy", bus_if.busy, 0);
        check("reset valid", bus_if.valid_o, 0);
        check("reset data", bus_if.data_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_msg("abcdef", s2q("abcdef"), 16'h0203, M_DEC, s2q("acebdf"), 1'b0);
        // N=5, M=2: buf[(k mod 2)*5 + k div 2]
        run_msg("hello52", s2q("HELLOWORLD"), 16'h0502, M_DEC, s2q("HWEOLRLLOD"), 1'b0);
        // N=2, M=5: buf[(k mod 5)*2 + k div 5]
        run_msg("hello25", s2q("HELLOWORLD"), 16'h0205, M_DEC, s2q("HLOOLELWRD"), 1'b0);
        run_msg("flush0204", s2q("abcdef"), 16'h0204, M_FLUSH, s2q(""), 1'b0);
        run_msg("flush0006", s2q("abcdef"), 16'h0006, M_FLUSH, s2q(""), 1'b0);
        run_msg("xyz", s2q("xyz123"), 16'h0302, M_DEC, s2q("x1y2z3"), 1'b0);
        run_msg("empty", s2q(""), 16'h0203, M_EMPTY, s2q(""), 1'b0);

        // 51 characters: the last one is dropped, N=10, M=5 covers exactly 50.
        for (int i = 0; i < 51; i++) long_msg.push_back(8'(8'h20 + i));
        for (int c = 0; c < 50; c++) long_exp.push_back(8'(8'h20 + (c % 5) * 10 + c / 5));
        run_msg("full", long_msg, 16'h0A05, M_DEC, long_exp, 1'b0);

        // Junk (including a token) while busy, then a back-to-back message.
        run_msg("junk", s2q("abcdef"), 16'h0302, M_DEC, s2q("adbecf"), 1'b1);
        run_msg("b2b", s2q("PQRS"), 16'h0202, M_DEC, s2q("PRQS"), 1'b0);

        // Reset on the third output cycle.
        for (int i = 0; i < 6; i++) begin
            bus_if.valid_i = 1'b1;
            bus_if.data_i  = 8'(8'h61 + i);
            @(negedge clk);
        end
        bus_if.data_i = START_DECRYPTION_TOKEN;
        bus_if.key    = 16'h0203;
        @(negedge clk);
        bus_if.valid_i = 1'b0;
        bus_if.data_i  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst pre valid", bus_if.valid_o, 1);
        check("rst pre data", bus_if.data_o, 8'h65);
        rst_n = 1'b0;
        #1;
        check("rst busy", bus_if.busy, 0);
        check("rst valid", bus_if.valid_o, 0);
        check("rst data", bus_if.data_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_if.valid_o || bus_if.busy) seen++;
        end
        check("rst no output", seen, 0);
        $display("reset mid-decrypt done");

        run_msg("post_rst", s2q("abcdef"), 16'h0203, M_DEC, s2q("acebdf"), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
